bank_row_sequencer: RTL

- Per-bank command sequencer that sits directly upstream of the Bank model.
- Accepts DRAM-style ACT/RD/WR/PRE commands carrying a full device row address.
- Maps that row onto one of the CHROWS physical row slots held in the Bank's BRAM.
- Drives the Bank's rd_o_wr, row and column inputs beat by beat for each burst, and enforces tRCD/tRP spacing.

---
 rtl/bank_row_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bank_row_sequencer.sv
// Per-bank command sequencer: maps device rows onto BRAM row slots and
// drives the Bank beat by beat, enforcing tRCD/tRP spacing.
module bank_row_sequencer #(
    parameter int ROWWIDTH = 16,
    parameter int COLWIDTH = 10,
    parameter int CHWIDTH  = 5,
    parameter int BLWIDTH  = 3,
    parameter int TRCD     = 4,
    parameter int TRP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          cmd,
    input  logic [ROWWIDTH-1:0] row_addr,
    input  logic [COLWIDTH-1:0] col_addr,
    output logic                bank_rd_o_wr,
    output logic [CHWIDTH-1:0]  bank_row,
    output logic [COLWIDTH-1:0] bank_column,
    output logic                beat_valid,
    output logic                busy,
    output logic                row_open,
    output logic                cmd_err,
    output logic                evict
);

    localparam int CHROWS = 1 << CHWIDTH;
    localparam int BL     = 1 << BLWIDTH;

    typedef enum logic [2:0] {
        IDLE, ACTIVATING, ACTIVE, BURST, PRECHARGING
    } state_t;

    state_t state, state_n;

    logic [3:0]          cnt;
    logic [BLWIDTH-1:0]  beat;
    logic [CHROWS-1:0]   valid;
    logic [ROWWIDTH-1:0] tag [CHROWS];
    logic [CHWIDTH-1:0]  rr;
    logic [CHWIDTH-1:0]  hit_idx;
    logic [CHWIDTH-1:0]  free_idx;
    logic                hit;
    logic                has_free;
    logic                is_act;
    logic                is_rw;
    logic                is_pre;
    logic                err;

    assign is_act = (cmd == 3'd1);
    assign is_rw  = (cmd == 3'd2) || (cmd == 3'd3);
    assign is_pre = (cmd == 3'd4);

    // Scanning downward leaves the lowest-index free slot in free_idx.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = CHROWS - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == row_addr) begin
                hit     = 1'b1;
                hit_idx = CHWIDTH'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = CHWIDTH'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        err     = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_act)
                    state_n = (TRCD == 1) ? ACTIVE : ACTIVATING;
                else if (is_rw)
                    err = 1'b1;
            end
            ACTIVATING: begin
                err = is_act || is_rw || is_pre;
                if (cnt == 4'd1)
                    state_n = ACTIVE;
            end
            ACTIVE: begin
                if (is_rw)
                    state_n = BURST;
                else if (is_pre)
                    state_n = (TRP == 1) ? IDLE : PRECHARGING;
                else if (is_act)
                    err = 1'b1;
            end
            BURST: begin
                err = is_act || is_rw || is_pre;
                if (beat == BLWIDTH'(BL - 1))
                    state_n = ACTIVE;
            end
            PRECHARGING: begin
                err = is_act || is_rw || is_pre;
                if (cnt == 4'd1)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            rr           <= '0;
            cnt          <= '0;
            beat         <= '0;
            bank_rd_o_wr <= 1'b0;
            bank_row     <= '0;
            bank_column  <= '0;
            beat_valid   <= 1'b0;
            busy         <= 1'b0;
            row_open     <= 1'b0;
            cmd_err      <= 1'b0;
            evict        <= 1'b0;
        end else begin
            state    <= state_n;
            cmd_err  <= err;
            evict    <= 1'b0;
            busy     <= !(state_n == IDLE || state_n == ACTIVE);
            row_open <= (state_n == ACTIVATING) || (state_n == ACTIVE)
                        || (state_n == BURST);
            unique case (state)
                IDLE: begin
                    if (is_act) begin
                        cnt <= 4'(TRCD - 1);
                        if (hit) begin
                            bank_row <= hit_idx;
                        end else if (has_free) begin
                            bank_row        <= free_idx;
                            valid[free_idx] <= 1'b1;
                            tag[free_idx]   <= row_addr;
                        end else begin
                            bank_row <= rr;
                            tag[rr]  <= row_addr;
                            rr       <= rr + CHWIDTH'(1);
                            evict    <= 1'b1;
                        end
                    end
                end
                ACTIVATING, PRECHARGING: cnt <= cnt - 4'd1;
                ACTIVE: begin
                    if (is_rw) begin
                        beat         <= '0;
                        beat_valid   <= 1'b1;
                        bank_rd_o_wr <= (cmd == 3'd3);
                        bank_column  <= col_addr;
                    end else if (is_pre) begin
                        cnt <= 4'(TRP - 1);
                    end
                end
                BURST: begin
                    if (beat == BLWIDTH'(BL - 1)) begin
                        beat_valid   <= 1'b0;
                        bank_rd_o_wr <= 1'b0;
                    end else begin
                        // Wrap within the BL-aligned block.
                        beat <= beat + BLWIDTH'(1);
                        bank_column[BLWIDTH-1:0] <=
                            bank_column[BLWIDTH-1:0] + BLWIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
